// File: rtl/mc_control_fsm.sv
// Multicycle ARM control unit: Moore sequencer from FETCH through writeback plus
// ALU/flag decode. Raw write strobes leave here ungated by the condition check.
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t state_q, state_d;

  logic [3:0] cmd;
  logic       s_bit;
  logic       alu_op;
  logic       branch;
  logic       irwrite_raw;
  logic       nextpc_raw;
  logic       regw_raw;
  logic       memw_raw;
  logic [1:0] alu_dec;
  logic       cmd_ok;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    cmd_ok  = 1'b1;
    alu_dec = 2'b00;
    case (cmd)
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    irwrite_raw = 1'b0;
    nextpc_raw  = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = 1'b0;
    branch      = 1'b0;
    regw_raw    = 1'b0;
    memw_raw    = 1'b0;
    case (state_q)
      FETCH: begin
        irwrite_raw = 1'b1;
        nextpc_raw  = 1'b1;
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        regw_raw  = 1'b1;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        memw_raw = 1'b1;
      end
      EXECR: alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: regw_raw = 1'b1;
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUControl = alu_op ? alu_dec : 2'b00;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};

  // Strobes are forced low whenever reset is held so a mid-instruction reset squashes writes at once.
  assign IRWrite = irwrite_raw & reset;
  assign NextPC  = nextpc_raw & reset;
  assign RegW    = regw_raw & reset;
  assign MemW    = memw_raw & reset;
  assign PCS     = ((regw_raw & (state_q == ALUWB) & (Rd == 4'd15)) | branch) & reset;
  assign FlagW   = (alu_op & cmd_ok & s_bit & reset) ?
                   {1'b1, (cmd == 4'b0100) | (cmd == 4'b0010)} : 2'b00;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed and random instructions checked cycle by cycle
// against a per-instruction-class phase model.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] op_i = 2'b00;
  logic [5:0] funct_i = 6'b0;
  logic [3:0] rd_i = 4'd0;

  logic       IRWrite, NextPC, AdrSrc, PCS, RegW, MemW;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, FlagW;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] obs_vec;

  mc_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(op_i), .Funct(funct_i), .Rd(rd_i),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW)
  );

  always #5 clk = ~clk;

  assign obs_vec = {12'b0, IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
                    ALUControl, ImmSrc, RegSrc, FlagW, PCS, RegW, MemW};

  function automatic logic [31:0] pack_out(input logic irw, input logic npc, input logic adr,
                                           input logic [1:0] res, input logic [1:0] srca,
                                           input logic [1:0] srcb, input logic [1:0] aluc,
                                           input logic [1:0] flagw, input logic pcs,
                                           input logic regw, input logic memw,
                                           input logic [1:0] op);
    return {12'b0, irw, npc, adr, res, srca, srcb, aluc, op,
            {op == 2'b01, op == 2'b10}, flagw, pcs, regw, memw};
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [5:0] funct);
    case (op)
      2'b00:   return 4;
      2'b01:   return funct[0] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // Expected outputs for phase k (0 = fetch) of one instruction, from the instruction's class.
  function automatic logic [31:0] model_out(input logic [1:0] op, input logic [5:0] funct,
                                            input logic [3:0] rd, input int k);
    int cmd;
    logic [1:0] aluc;
    logic [1:0] flagw;
    cmd = int'(funct[4:1]);
    aluc = (cmd == 4) ? 2'd0 : (cmd == 2) ? 2'd1 : (cmd == 0) ? 2'd2 : (cmd == 12) ? 2'd3 : 2'd0;
    flagw = 2'b00;
    if (funct[0] && (cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12))
      flagw = {1'b1, (cmd == 4 || cmd == 2)};
    if (k == 0) return pack_out(1, 1, 0, 2, 1, 2, 0, 0, 0, 0, 0, op);
    if (k == 1) return pack_out(0, 0, 0, 2, 1, 2, 0, 0, 0, 0, 0, op);
    case (op)
      2'b00:
        if (k == 2) return pack_out(0, 0, 0, 0, 0, funct[5] ? 2'd1 : 2'd0, aluc, flagw, 0, 0, 0, op);
        else        return pack_out(0, 0, 0, 0, 0, 0, 0, 0, rd == 4'd15, 1, 0, op);
      2'b01:
        if (k == 2)          return pack_out(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, op);
        else if (!funct[0])  return pack_out(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, op);
        else if (k == 3)     return pack_out(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, op);
        else                 return pack_out(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, op);
      default: return pack_out(0, 0, 0, 2, 2, 1, 0, 0, 1, 0, 0, op);
    endcase
  endfunction

  function automatic logic [31:0] reset_out(input logic [1:0] op);
    return pack_out(0, 0, 0, 2, 1, 2, 0, 0, 0, 0, 0, op);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %05h, expected %05h", tag, observed, expected);
    end
  endtask

  // Runs ncyc phases of one instruction starting at a mid-cycle point in FETCH.
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                               input int ncyc, input string name);
    op_i = op;
    funct_i = funct;
    rd_i = rd;
    #1;
    for (int k = 0; k < ncyc; k++) begin
      checkOutput($sformatf("%s op=%0b f=%06b rd=%0d c%0d", name, op, funct, rd, k),
                  obs_vec, model_out(op, funct, rd, k));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic resetMidInstr(input logic [1:0] op, input logic [5:0] funct, input string name);
    applyStimulus(op, funct, 4'd2, 2, name);
    checkOutput({name, " before"}, obs_vec, model_out(op, funct, 4'd2, 2));
    #2 reset = 1'b0;
    #1 checkOutput({name, " drop"}, obs_vec, reset_out(op));
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " held"}, obs_vec, reset_out(op));
    reset = 1'b1;
    #1 checkOutput({name, " restart"}, obs_vec, model_out(op, funct, 4'd2, 0));
  endtask

  initial begin
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    @(negedge clk);
    checkOutput("reset op00", obs_vec, reset_out(2'b00));
    op_i = 2'b10;
    @(negedge clk);
    checkOutput("reset op10", obs_vec, reset_out(2'b10));
    op_i = 2'b00;
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(2'b00, 6'b001000, 4'd1, 4, "add");
    applyStimulus(2'b00, 6'b100101, 4'd2, 4, "subs_imm");
    applyStimulus(2'b01, 6'b011001, 4'd3, 5, "ldr");
    applyStimulus(2'b01, 6'b011000, 4'd4, 4, "str");
    applyStimulus(2'b10, 6'b000000, 4'd0, 3, "b");
    applyStimulus(2'b00, 6'b011000, 4'd15, 4, "orr_pc");
    applyStimulus(2'b11, 6'b111111, 4'd15, 2, "undef");
    applyStimulus(2'b00, 6'b000001, 4'd5, 4, "ands");
    applyStimulus(2'b00, 6'b111111, 4'd6, 4, "unsupported");
    applyStimulus(2'b01, 6'b011001, 4'd15, 5, "ldr_pc");

    resetMidInstr(2'b01, 6'b011001, "rst_memadr");
    resetMidInstr(2'b00, 6'b100101, "rst_execi");

    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      applyStimulus(op, funct, rd, latency(op, funct), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
